// File: rtl/reg_bus_initiator.sv
// Register-bus initiator: queues host commands in a small FIFO and issues them one at a
// time to a CSR responder, returning one in-order response per command with timeout guard.

package reg_bus_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    // Queued command as accepted from the host side
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

endpackage

module reg_bus_initiator #(
    parameter type         reg_req_t      = reg_bus_pkg::reg_req_t,
    parameter type         reg_rsp_t      = reg_bus_pkg::reg_rsp_t,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_write_i,
    input  logic [31:0]              cmd_addr_i,
    input  logic [31:0]              cmd_wdata_i,
    input  logic [3:0]               cmd_wstrb_i,
    output reg_req_t                 reg_req_o,
    input  reg_rsp_t                 reg_rsp_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [31:0]              rsp_rdata_o,
    output logic                     rsp_error_o,
    output logic                     rsp_timeout_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned LW      = PW + 1;
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    reg_bus_pkg::cmd_t r_mem [DEPTH];
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [LW-1:0]     r_level;
    state_e            r_state, w_state_next;
    reg_req_t          r_req;
    logic [15:0]       r_tcnt;
    logic              r_rsp_valid, r_rsp_error, r_rsp_timeout;
    logic [31:0]       r_rsp_rdata;

    logic              w_full, w_empty, w_push, w_pop, w_complete, w_abandon;
    reg_bus_pkg::cmd_t w_head;

    // Ready depends on occupancy only, so a full FIFO never accepts even while popping
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = cmd_valid_i && !w_full;
    assign w_head  = r_mem[r_rptr];

    assign cmd_ready_o   = !w_full;
    assign level_o       = r_level;
    assign busy_o        = !w_empty || (r_state != StIdle);
    assign reg_req_o     = r_req;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_error_o   = r_rsp_error;
    assign rsp_timeout_o = r_rsp_timeout;

    // FIFO storage write port; contents need no reset since level gates every read
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{write: cmd_write_i, addr: cmd_addr_i,
                               wdata: cmd_wdata_i, wstrb: cmd_wstrb_i};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    // FSM next state plus pop/complete/abandon strobes
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_complete   = 1'b0;
        w_abandon    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = StReq;
                end
            end
            StReq: begin
                // A ready in the final timeout cycle still completes normally
                if (reg_rsp_i.ready) begin
                    w_complete   = 1'b1;
                    w_state_next = StResp;
                end else if ((TIMEOUT_CYCLES != 0) && (r_tcnt == TmoLast)) begin
                    w_abandon    = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = StReq;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Request register and timeout counter; reads drive zero wdata/wstrb on the bus
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req  <= '0;
            r_tcnt <= '0;
        end else if (w_pop) begin
            r_req.addr  <= w_head.addr;
            r_req.write <= w_head.write;
            r_req.wdata <= w_head.write ? w_head.wdata : '0;
            r_req.wstrb <= w_head.write ? w_head.wstrb : '0;
            r_req.valid <= 1'b1;
            r_tcnt      <= '0;
        end else if (w_complete || w_abandon) begin
            r_req <= '0;
        end else if (r_state == StReq) begin
            r_tcnt <= r_tcnt + 16'd1;
        end
    end

    // Response register, held until the consumer takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_complete) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_req.write ? '0 : reg_rsp_i.rdata;
            r_rsp_error   <= reg_rsp_i.error;
            r_rsp_timeout <= 1'b0;
        end else if (w_abandon) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b1;
            r_rsp_timeout <= 1'b1;
        end else if (r_rsp_valid && rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule
